noc_vchannel_link_mux: RTL and testbench
========================================

// Module: noc_vchannel_link_mux
// PURPOSE
// - Multi-channel NoC link concentrator: CHANNELS independent flit streams enter, each with a
//   BUFFER_SIZE-deep FIFO, and are merged onto one physical output link tagged with a channel index.
// - Sits between a router output port and the inter-node link of the X*Y 2D mesh.
// - Mode select: flit-interleaved virtual channels (ENABLE_VCHANNELS=1) or packet-locked wormhole (0).
// PARAMETERS
// - FLIT_WIDTH        32  flit data width
// - CHANNELS          7   number of input channels, >=1
// - BUFFER_SIZE       4   per-channel FIFO depth, >=2, need not be a power of 2
// - ENABLE_VCHANNELS  1   1 = re-arbitrate on every flit; 0 = hold grant until last flit of packet
// - CW (local)            CHANNELS>1 ? $clog2(CHANNELS) : 1
// - FW (local)            $clog2(BUFFER_SIZE+1)
// PORTS
// - clk        in   1                   clock, all logic on rising edge
// - rst        in   1                   asynchronous active-low reset (0 = reset)
// - in_flit    in   CHANNELS*FLIT_WIDTH per-channel flit, channel c at [c*FLIT_WIDTH +: FLIT_WIDTH]
// - in_last    in   CHANNELS            per-channel last-flit-of-packet marker
// - in_valid   in   CHANNELS            per-channel flit valid
// - in_ready   out  CHANNELS            per-channel FIFO not full
// - out_flit   out  FLIT_WIDTH          head flit of granted channel
// - out_last   out  1                   last marker of out_flit
// - out_channel out CW                  index of granted channel
// - out_valid  out  1                   output flit valid
// - out_ready  in   1                   downstream accepts flit
// - fill       out  CHANNELS*FW         per-channel FIFO occupancy, 0..BUFFER_SIZE
// BEHAVIOUR
// - Reset (rst=0, async assert, sync release): FIFOs empty, pointers 0, fill=0, in_ready=0 during
//   reset then all 1, out_valid=0, out_flit/out_last/out_channel=0, RR pointer=0, lock cleared.
// - Input push c: in_valid[c]&in_ready[c]. in_ready[c] = fill[c]!=BUFFER_SIZE, registered-equivalent;
//   no combinational path from out_ready to in_ready. in_valid while full is ignored, flit not stored.
// - Pointers wrap BUFFER_SIZE-1 -> 0. Push+pop same cycle on one channel: fill unchanged, legal
//   also at fill=BUFFER_SIZE-1 and at fill=1; pop on full channel frees the slot next cycle.
// - Output registered: flit pushed at edge N is earliest on out_* after edge N+1 (1-cycle latency).
// - Output handshake: transfer when out_valid&out_ready. While out_valid=1 and out_ready=0,
//   out_flit/out_last/out_channel held stable; no re-arbitration.
// - Arbiter: round-robin over channels with fill>0 (excluding the flit already in the output reg),
//   search starts at last granted index+1, wraps CHANNELS-1 -> 0. Evaluated whenever output reg
//   is empty or being consumed this cycle; back-to-back flits at 1 flit/cycle sustained.
// - ENABLE_VCHANNELS=1: new grant after every transferred flit; channels interleave flit by flit.
// - ENABLE_VCHANNELS=0: FSM IDLE -> LOCKED(c) on first flit of a packet from c; stays on c (even if
//   c runs empty, output idles) until a flit with last=1 is loaded; then IDLE, RR advances past c.
// - Single-flit packet (last on first flit) never enters LOCKED.
// - Reset mid-packet: all buffered flits discarded, lock cleared; no partial-packet recovery.
// - fill[c] reflects state after the last edge; counts flits in FIFO only, not the output register.
// TESTING
// - Reset: rst=0 with in_valid=all 1 -> out_valid=0, fill=0, nothing stored; release -> in_ready=all 1.
// - Single flit ch2 0xDEADBEEF last=1, out_ready=1 -> out_flit=0xDEADBEEF, out_channel=2 one cycle later.
// - Fill ch0 with 5 flits, BUFFER_SIZE=4, out_ready=0 -> fill[0]=4, in_ready[0]=0, 5th flit dropped;
//   then out_ready=1 -> exactly 4 flits out in order.
// - VC mode, ch1 and ch3 each 3-flit packets queued, out_ready=1 -> out_channel sequence 1,3,1,3,1,3.
// - Wormhole mode same stimulus -> 1,1,1,3,3,3; out_ready toggled 0/1 randomly -> no flit lost or duplicated.
// - Backpressure: out_ready=0 for 10 cycles with valid flit -> out_* bit-stable; rst pulse mid-packet -> fill=0.

Source files
------------

// File: rtl/noc_vchannel_link_mux.sv
// Multi-channel NoC link concentrator: per-channel FIFOs merged onto one registered output link,
// round-robin arbitrated, either flit-interleaved (virtual channels) or packet-locked (wormhole).
module noc_vchannel_link_mux #(
  parameter int FLIT_WIDTH       = 32,
  parameter int CHANNELS         = 7,
  parameter int BUFFER_SIZE      = 4,
  parameter int ENABLE_VCHANNELS = 1,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int FW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic [CW-1:0]                  out_channel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*FW-1:0]         fill
);

  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int DW = FLIT_WIDTH + 1;

  typedef enum logic {IDLE, LOCKED} lock_state_e;

  logic [DW-1:0]       mem    [CHANNELS][BUFFER_SIZE];
  logic [PW-1:0]       wr_ptr [CHANNELS];
  logic [PW-1:0]       rd_ptr [CHANNELS];
  logic [FW-1:0]       cnt    [CHANNELS];
  logic                alive;
  logic [CHANNELS-1:0] push, pop, req;
  logic                load, take, grant_valid;
  logic [CW-1:0]       grant_idx, rr_ptr, lock_ch, lock_ch_next;
  logic [DW-1:0]       head;
  lock_state_e         state, state_next;

  // in_ready depends only on registered state; alive keeps it low until the first edge after reset.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      in_ready[c]          = alive && (cnt[c] != FW'(BUFFER_SIZE));
      fill[c*FW +: FW]     = cnt[c];
    end
  end

  assign push = in_valid & in_ready;
  assign load = !out_valid || out_ready;
  assign take = load && grant_valid;
  assign head = mem[grant_idx][rd_ptr[grant_idx]];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      req[c] = (cnt[c] != '0) && ((state != LOCKED) || (lock_ch == CW'(c)));
      pop[c] = take && (grant_idx == CW'(c));
    end
  end

  // Round-robin search starting one past the last grant.
  always_comb begin : arbiter
    int idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
  end

  always_comb begin
    state_next   = state;
    lock_ch_next = lock_ch;
    if ((ENABLE_VCHANNELS == 0) && take) begin
      unique case (state)
        IDLE: if (!head[DW-1]) begin
          state_next   = LOCKED;
          lock_ch_next = grant_idx;
        end
        LOCKED: if (head[DW-1]) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lock_ch <= '0;
      rr_ptr  <= '0;
      alive   <= 1'b0;
    end else begin
      state   <= state_next;
      lock_ch <= lock_ch_next;
      alive   <= 1'b1;
      if (take) rr_ptr <= (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_flit    <= '0;
      out_last    <= 1'b0;
      out_channel <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        {out_last, out_flit} <= head;
        out_channel          <= grant_idx;
      end
    end
  end

  // NOTE: the flit storage is deliberately not reset; occupancy counters alone define valid data.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= {in_last[c], in_flit[c*FLIT_WIDTH +: FLIT_WIDTH]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (push[c]) wr_ptr[c] <= (wr_ptr[c] == PW'(BUFFER_SIZE - 1)) ? '0 : wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= (rd_ptr[c] == PW'(BUFFER_SIZE - 1)) ? '0 : rd_ptr[c] + 1'b1;
        if (push[c] && !pop[c])      cnt[c] <= cnt[c] + 1'b1;
        else if (!push[c] && pop[c]) cnt[c] <= cnt[c] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_vchannel_link_mux.sv
// Directed bench: one virtual-channel and one wormhole instance share stimulus; outputs checked
// against hand-computed sequences.
module tb_noc_vchannel_link_mux;

  localparam int CH = 7;
  localparam int FB = 3;

  typedef struct packed {
    logic [2:0]  ch;
    logic        last;
    logic [31:0] flit;
  } xfer_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*32-1:0] in_flit;
  logic [CH-1:0]   in_last, in_valid;
  logic            out_ready;

  logic [CH-1:0]   vc_in_ready, wh_in_ready;
  logic [31:0]     vc_out_flit, wh_out_flit;
  logic            vc_out_last, wh_out_last;
  logic [2:0]      vc_out_channel, wh_out_channel;
  logic            vc_out_valid, wh_out_valid;
  logic [CH*FB-1:0] vc_fill, wh_fill;

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  xfer_t q_vc[$];
  xfer_t q_wh[$];
  xfer_t exp_vc[$];
  xfer_t exp_wh[$];

  noc_vchannel_link_mux #(.ENABLE_VCHANNELS(1)) dut_vc (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(vc_in_ready), .out_flit(vc_out_flit), .out_last(vc_out_last),
    .out_channel(vc_out_channel), .out_valid(vc_out_valid), .out_ready(out_ready), .fill(vc_fill)
  );

  noc_vchannel_link_mux #(.ENABLE_VCHANNELS(0)) dut_wh (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(wh_in_ready), .out_flit(wh_out_flit), .out_last(wh_out_last),
    .out_channel(wh_out_channel), .out_valid(wh_out_valid), .out_ready(out_ready), .fill(wh_fill)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (vc_out_valid && out_ready) q_vc.push_back({vc_out_channel, vc_out_last, vc_out_flit});
      if (wh_out_valid && out_ready) q_wh.push_back({wh_out_channel, wh_out_last, wh_out_flit});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic [31:0] data, input logic last);
    in_flit[c*32 +: 32] = data;
    in_last[c]          = last;
    in_valid[c]         = 1'b1;
  endtask

  function automatic logic [2:0] fill_at(input logic [CH*FB-1:0] f, input int c);
    return f[c*FB +: FB];
  endfunction

  task automatic check_seq(input string tag, input xfer_t got[$], input xfer_t exp[$]);
    xfer_t g;
    check({tag, ".count"}, 64'(got.size()), 64'(exp.size()));
    foreach (exp[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      check($sformatf("%s[%0d]", tag, i), 64'(g), 64'(exp[i]));
    end
  endtask

  // Per-channel order check for a run of three 3-flit packets on channels 1, 3, 6.
  task automatic check_order(input string tag, input xfer_t got[$], input bit contiguous);
    int  k [CH];
    bit  ok;
    for (int c = 0; c < CH; c++) k[c] = 0;
    check({tag, ".count"}, 64'(got.size()), 64'd9);
    foreach (got[i]) begin
      check($sformatf("%s.flit[%0d]", tag, i), 64'(got[i].flit),
            64'(32'h1000 * got[i].ch + 32'(k[got[i].ch])));
      check($sformatf("%s.last[%0d]", tag, i), 64'(got[i].last), 64'(k[got[i].ch] == 2));
      k[got[i].ch]++;
    end
    if (contiguous) begin
      for (int g = 0; g + 2 < got.size(); g += 3) begin
        ok = (got[g].ch == got[g+1].ch) && (got[g].ch == got[g+2].ch);
        check($sformatf("%s.contig[%0d]", tag, g / 3), 64'(ok), 64'd1);
      end
    end
  endtask

  initial begin
    // Reset with every input valid: nothing may be stored.
    rst       = 1'b0;
    in_valid  = '1;
    in_last   = '1;
    in_flit   = {CH{32'hA5A5_5A5A}};
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst.vc.out_valid", 64'(vc_out_valid), 64'd0);
    check("rst.wh.out_valid", 64'(wh_out_valid), 64'd0);
    check("rst.vc.fill", 64'(vc_fill), 64'd0);
    check("rst.vc.in_ready", 64'(vc_in_ready), 64'd0);
    check("rst.vc.out_flit", 64'(vc_out_flit), 64'd0);
    in_valid = '0;
    in_last  = '0;
    rst      = 1'b1;
    tick();
    check("rel.vc.in_ready", 64'(vc_in_ready), 64'h7F);
    check("rel.wh.in_ready", 64'(wh_in_ready), 64'h7F);
    check("rel.wh.fill", 64'(wh_fill), 64'd0);
    check("rel.vc.out_valid", 64'(vc_out_valid), 64'd0);

    // Single flit on channel 2, one-cycle latency.
    drive(2, 32'hDEAD_BEEF, 1'b1);
    tick();
    in_valid = '0;
    check("single.vc.fill2", 64'(fill_at(vc_fill, 2)), 64'd1);
    check("single.vc.early", 64'(vc_out_valid), 64'd0);
    tick();
    check("single.vc.valid", 64'(vc_out_valid), 64'd1);
    check("single.vc.flit", 64'(vc_out_flit), 64'hDEAD_BEEF);
    check("single.vc.ch", 64'(vc_out_channel), 64'd2);
    check("single.vc.last", 64'(vc_out_last), 64'd1);
    check("single.wh.flit", 64'(wh_out_flit), 64'hDEAD_BEEF);
    check("single.wh.ch", 64'(wh_out_channel), 64'd2);
    check("single.vc.fill_after", 64'(vc_fill), 64'd0);
    tick();
    check("single.vc.drained", 64'(vc_out_valid), 64'd0);

    // Output register held by a ch5 flit, then ch0 filled past capacity.
    out_ready = 1'b0;
    drive(5, 32'h55, 1'b1);
    tick();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'hA0 + 32'(i), i == 3);
      tick();
    end
    check("full.vc.fill0", 64'(fill_at(vc_fill, 0)), 64'd4);
    check("full.wh.fill0", 64'(fill_at(wh_fill, 0)), 64'd4);
    check("full.vc.in_ready0", 64'(vc_in_ready[0]), 64'd0);
    check("full.wh.in_ready0", 64'(wh_in_ready[0]), 64'd0);
    drive(0, 32'hA4, 1'b1);
    tick();
    in_valid = '0;
    check("drop.vc.fill0", 64'(fill_at(vc_fill, 0)), 64'd4);
    check("drop.vc.ch", 64'(vc_out_channel), 64'd5);
    check("drop.vc.flit", 64'(vc_out_flit), 64'h55);
    q_vc.delete(); q_wh.delete();
    mon_en    = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    mon_en = 1'b0;
    exp_vc = {};
    exp_vc.push_back({3'd5, 1'b1, 32'h55});
    for (int i = 0; i < 4; i++) exp_vc.push_back({3'd0, 1'(i == 3), 32'hA0 + 32'(i)});
    check_seq("full.vc", q_vc, exp_vc);
    check_seq("full.wh", q_wh, exp_vc);
    check("full.vc.empty", 64'(vc_fill), 64'd0);

    // Two 3-flit packets on channels 1 and 3 queued, then drained.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h100 + 32'(k), k == 2);
      drive(3, 32'h300 + 32'(k), k == 2);
      tick();
    end
    in_valid = '0;
    check("pkt.vc.fill1", 64'(fill_at(vc_fill, 1)), 64'd2);
    check("pkt.vc.fill3", 64'(fill_at(vc_fill, 3)), 64'd3);
    check("pkt.wh.fill3", 64'(fill_at(wh_fill, 3)), 64'd3);
    check("pkt.vc.head", 64'(vc_out_flit), 64'h100);
    q_vc.delete(); q_wh.delete();
    mon_en    = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    mon_en = 1'b0;
    exp_vc = {};
    exp_wh = {};
    for (int k = 0; k < 3; k++) begin
      exp_vc.push_back({3'd1, 1'(k == 2), 32'h100 + 32'(k)});
      exp_vc.push_back({3'd3, 1'(k == 2), 32'h300 + 32'(k)});
      exp_wh.push_back({3'd1, 1'(k == 2), 32'h100 + 32'(k)});
    end
    for (int k = 0; k < 3; k++) exp_wh.push_back({3'd3, 1'(k == 2), 32'h300 + 32'(k)});
    check_seq("vc.interleave", q_vc, exp_vc);
    check_seq("wh.locked", q_wh, exp_wh);

    // Random backpressure while three packets stream in: no loss, no duplication.
    q_vc.delete(); q_wh.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive(1, 32'h1000 + 32'(k), k == 2);
      drive(3, 32'h3000 + 32'(k), k == 2);
      drive(6, 32'h6000 + 32'(k), k == 2);
      tick();
    end
    in_valid = '0;
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    repeat (12) tick();
    mon_en = 1'b0;
    check_order("rand.vc", q_vc, 1'b0);
    check_order("rand.wh", q_wh, 1'b1);

    // Stall with a valid flit mid-packet: outputs must not move.
    out_ready = 1'b0;
    drive(4, 32'h44, 1'b0);
    tick();
    drive(4, 32'h45, 1'b0);
    tick();
    in_valid = '0;
    for (int i = 0; i < 10; i++) begin
      check("stall.vc.valid", 64'(vc_out_valid), 64'd1);
      check("stall.vc.flit", 64'(vc_out_flit), 64'h44);
      check("stall.wh.flit", 64'(wh_out_flit), 64'h44);
      check("stall.wh.ch", 64'(wh_out_channel), 64'd4);
      tick();
    end
    check("stall.wh.fill4", 64'(fill_at(wh_fill, 4)), 64'd1);

    // Asynchronous reset mid-packet clears buffers and the wormhole lock.
    rst = 1'b0;
    #1;
    check("midrst.vc.fill", 64'(vc_fill), 64'd0);
    check("midrst.wh.fill", 64'(wh_fill), 64'd0);
    check("midrst.wh.valid", 64'(wh_out_valid), 64'd0);
    check("midrst.wh.in_ready", 64'(wh_in_ready), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst.wh.rel_ready", 64'(wh_in_ready), 64'h7F);
    drive(6, 32'h66, 1'b1);
    drive(2, 32'h22, 1'b1);
    tick();
    in_valid = '0;
    q_vc.delete(); q_wh.delete();
    mon_en    = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    mon_en = 1'b0;
    exp_vc = {};
    exp_vc.push_back({3'd2, 1'b1, 32'h22});
    exp_vc.push_back({3'd6, 1'b1, 32'h66});
    check_seq("post.vc", q_vc, exp_vc);
    check_seq("post.wh", q_wh, exp_vc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
